alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Arbitrates the single datapath ALU between the CPU execute stage and the DMA engine, which uses it for address increment and transfer-count compares. Each cycle it grants at most one requester and steers that requester's operands and 3-bit ALU function onto the ALU inputs. It captures the ALU result and zero flag in an output register and signals completion to the owner one cycle later. CPU has fixed priority, and a starvation counter guarantees DMA forward progress.

## Interface
- WIDTH, 32, operand/result width
- MAX_WAIT, 4, max consecutive contended cycles DMA may lose before a forced DMA grant (legal range ≥1)
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- req_cpu  in  1  CPU requests an ALU operation this cycle
- a_cpu, b_cpu  in  WIDTH  CPU operands
- funct_cpu  in  3  CPU ALU function: 000 add, 001 sub, 011 and, 100 or, 110 nor
- req_dma  in  1  DMA requests an ALU operation this cycle
- a_dma, b_dma  in  WIDTH  DMA operands
- funct_dma  in  3  DMA ALU function, same encoding
- gnt_cpu, gnt_dma  out  1  combinational grant, one-hot or zero
- alu_a, alu_b  out  WIDTH  to ALU operand inputs
- alu_funct  out  3  to ALU function select
- alu_result  in  WIDTH  combinational ALU result
- alu_zero  in  1  ALU zero flag
- result_q  out  WIDTH  registered result
- zero_q  out  1  registered zero flag
- done_cpu, done_dma  out  1  one-cycle pulse: result_q/zero_q belong to that requester

## Operation
- Grant rule per cycle:
  - Only one requester asserts → it wins.
  - Both assert → CPU wins, unless wait_cnt == MAX_WAIT, in which case DMA wins.
  - Neither asserts → no grant.
- wait_cnt (width $clog2(MAX_WAIT+1), reset 0):
  - Increments when both request and CPU wins.
  - Clears when DMA is granted or req_dma is low.
  - Never exceeds MAX_WAIT.
- Operand steering:
  - Granted requester's a/b/funct drive alu_a/alu_b/alu_funct.
  - No grant → alu_a = 0, alu_b = 0, alu_funct = 000.
- Owner FSM, states S_IDLE, S_CPU, S_DMA, recording who owns the result register:
  - Next state is S_CPU on gnt_cpu, S_DMA on gnt_dma, otherwise S_IDLE.
  - done_cpu = (state == S_CPU); done_dma = (state == S_DMA).
- result_q/zero_q load alu_result/alu_zero on any grant and hold otherwise.
- Requester handshake: a requester holds req until it sees gnt. It may keep req high after gnt to issue back-to-back ops, presenting new operands each cycle. Ungranted operands are ignored, not queued.
- Arithmetic is entirely inside the ALU. The block performs no width conversion; result_q is WIDTH bits verbatim.

## Timing
- Reset values: gnt_* = 0 when req low, result_q = 0, zero_q = 0, done_* = 0, state = S_IDLE, wait_cnt = 0.
- gnt is combinational from req_* and wait_cnt in the same cycle N.
- The ALU evaluates in cycle N. result_q, zero_q and done_x are valid in cycle N+1.
- Throughput is one op per cycle, and ops may alternate owners every cycle.
- With continuous contention and MAX_WAIT = M, grants follow the repeating pattern of M CPU grants then 1 DMA grant.
- Reset asserted in cycle N+1, after a cycle-N grant: the pending result is discarded and done_* stays 0 in N+2. Reset dominates all requests, so no gnt is asserted while reset is high.
- req dropping in the same cycle as a would-be forced DMA grant: the grant goes to CPU if req_cpu is high, and wait_cnt clears.

## Structure
- Shared package alu_pkg holds:
  - function constants ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b011, ALU_OR = 3'b100, ALU_NOR = 3'b110;
  - owner state encoding S_IDLE, S_CPU, S_DMA.
- One sub-module is natural: alu_starve_cnt. It contains the saturating wait counter plus the grant decision, and outputs gnt_cpu/gnt_dma. The top level keeps the steering mux, result register and owner FSM.

## Test plan
- Reset held 3 cycles with both req high → all gnt/done = 0, result_q = 0, zero_q = 0.
- CPU only, a = 5, b = 3, funct = 001 → gnt_cpu = 1 same cycle, alu_funct = 001; next cycle done_cpu = 1, result_q = 2, zero_q = 0.
- Both req high continuously, MAX_WAIT = 4 → gnt sequence C, C, C, C, D, C, C, C, C, D; done pulses follow one cycle later with matching owners.
- DMA only, three back-to-back adds (0x100 + 4, 0x104 + 4, 0x108 + 4) → done_dma high 3 consecutive cycles with result_q 0x104, 0x108, 0x10C.
- CPU sub 7 − 7 granted, reset asserted next cycle → done_cpu stays 0, result_q = 0, zero_q = 0. After reset, the same op yields zero_q = 1, result_q = 0.
- Idle cycle between ops → alu_a = alu_b = 0, alu_funct = 000; result_q holds its previous value, done_* = 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU function encodings and the result-owner state encoding
// used by the ALU share arbiter and its starvation counter.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_NOR = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_DMA  = 2'd2
    } owner_t;

endpackage

// File: rtl/alu_starve_cnt.sv
// CPU-priority grant decision with a saturating DMA starvation counter.
// Grants are combinational in the request cycle; losers must hold req.
module alu_starve_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req_cpu,
    input  logic req_dma,
    output logic gnt_cpu,
    output logic gnt_dma
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

    logic [CW-1:0] wait_cnt;

    always_comb begin
        gnt_cpu = 1'b0;
        gnt_dma = 1'b0;
        if (!reset) begin
            if (req_cpu && req_dma) begin
                // DMA has lost MAX_WAIT contended cycles in a row: force it through
                if (wait_cnt == WAIT_LIM) begin
                    gnt_dma = 1'b1;
                end else begin
                    gnt_cpu = 1'b1;
                end
            end else if (req_cpu) begin
                gnt_cpu = 1'b1;
            end else if (req_dma) begin
                gnt_dma = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (gnt_dma || !req_dma) begin
            wait_cnt <= '0;
        end else if (gnt_cpu && (wait_cnt != WAIT_LIM)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between CPU and DMA: steers the granted operands, registers the result.
// Grant in cycle N, result_q/zero_q/done_* in N+1; ungranted requester holds req and retries.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_cpu,
    input  logic [WIDTH-1:0] a_cpu,
    input  logic [WIDTH-1:0] b_cpu,
    input  logic [2:0]       funct_cpu,
    input  logic             req_dma,
    input  logic [WIDTH-1:0] a_dma,
    input  logic [WIDTH-1:0] b_dma,
    input  logic [2:0]       funct_dma,
    output logic             gnt_cpu,
    output logic             gnt_dma,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_funct,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic [WIDTH-1:0] result_q,
    output logic             zero_q,
    output logic             done_cpu,
    output logic             done_dma
);

    owner_t state_q;
    owner_t state_d;

    alu_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk     (clk),
        .reset   (reset),
        .req_cpu (req_cpu),
        .req_dma (req_dma),
        .gnt_cpu (gnt_cpu),
        .gnt_dma (gnt_dma)
    );

    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_funct = ALU_ADD;
        if (gnt_cpu) begin
            alu_a     = a_cpu;
            alu_b     = b_cpu;
            alu_funct = funct_cpu;
        end else if (gnt_dma) begin
            alu_a     = a_dma;
            alu_b     = b_dma;
            alu_funct = funct_dma;
        end
    end

    // Owner of the result register, one cycle behind the grant
    always_comb begin
        state_d = S_IDLE;
        if (gnt_cpu) begin
            state_d = S_CPU;
        end else if (gnt_dma) begin
            state_d = S_DMA;
        end
        done_cpu = (state_q == S_CPU);
        done_dma = (state_q == S_DMA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else if (gnt_cpu || gnt_dma) begin
            result_q <= alu_result;
            zero_q   <= alu_zero;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a bench-side ALU, a request-level model
// checked every cycle, and hand-computed pinned expectations.
module tb_alu_share_arbiter;

    localparam int WIDTH    = 32;
    localparam int MAX_WAIT = 4;

    logic             clk;
    logic             reset;
    logic             req_cpu, req_dma;
    logic [WIDTH-1:0] a_cpu, b_cpu, a_dma, b_dma;
    logic [2:0]       funct_cpu, funct_dma;
    logic             gnt_cpu, gnt_dma;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result, result_q;
    logic [2:0]       alu_funct;
    logic             alu_zero, zero_q, done_cpu, done_dma;

    alu_share_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_cpu    (req_cpu),
        .a_cpu      (a_cpu),
        .b_cpu      (b_cpu),
        .funct_cpu  (funct_cpu),
        .req_dma    (req_dma),
        .a_dma      (a_dma),
        .b_dma      (b_dma),
        .funct_dma  (funct_dma),
        .gnt_cpu    (gnt_cpu),
        .gnt_dma    (gnt_dma),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_funct  (alu_funct),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .result_q   (result_q),
        .zero_q     (zero_q),
        .done_cpu   (done_cpu),
        .done_dma   (done_dma)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [2:0] f);
        case (f)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b011:  return a & b;
            3'b100:  return a | b;
            3'b110:  return ~(a | b);
            default: return '0;
        endcase
    endfunction

    // The ALU itself lives in the bench
    always_comb begin
        alu_result = alu_fn(alu_a, alu_b, alu_funct);
        alu_zero   = (alu_result == '0);
    end

    int nchk  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pinned expectations posted by the stimulus for the upcoming compare edge
    logic             pin_vld = 1'b0;
    logic             pin_gc, pin_gd, pin_done_en, pin_dc, pin_dd, pin_res_en, pin_zero;
    logic [WIDTH-1:0] pin_res;

    // Model state: consecutive contended losses, owner of the pending result, registered values
    int               lost = 0;
    int               owner = 0;   // 0 none, 1 cpu, 2 dma
    logic [WIDTH-1:0] m_res = '0;
    logic             m_zero = 1'b0;
    logic             mc, md;
    logic [WIDTH-1:0] ea, eb;
    logic [2:0]       ef;

    always @(negedge clk) begin
        mc = 1'b0;
        md = 1'b0;
        if (!reset) begin
            if (req_cpu && req_dma) begin
                if (lost >= MAX_WAIT) md = 1'b1;
                else                  mc = 1'b1;
            end else begin
                mc = req_cpu;
                md = req_dma;
            end
        end
        ea = mc ? a_cpu : (md ? a_dma : '0);
        eb = mc ? b_cpu : (md ? b_dma : '0);
        ef = mc ? funct_cpu : (md ? funct_dma : 3'b000);

        chk("gnt_cpu", {31'b0, gnt_cpu}, {31'b0, mc});
        chk("gnt_dma", {31'b0, gnt_dma}, {31'b0, md});
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_funct", {29'b0, alu_funct}, {29'b0, ef});
        chk("done_cpu", {31'b0, done_cpu}, {31'b0, owner == 1});
        chk("done_dma", {31'b0, done_dma}, {31'b0, owner == 2});
        chk("result_q", result_q, m_res);
        chk("zero_q", {31'b0, zero_q}, {31'b0, m_zero});

        if (pin_vld) begin
            chk("pin_gnt_cpu", {31'b0, gnt_cpu}, {31'b0, pin_gc});
            chk("pin_gnt_dma", {31'b0, gnt_dma}, {31'b0, pin_gd});
            if (pin_done_en) begin
                chk("pin_done_cpu", {31'b0, done_cpu}, {31'b0, pin_dc});
                chk("pin_done_dma", {31'b0, done_dma}, {31'b0, pin_dd});
            end
            if (pin_res_en) begin
                chk("pin_result_q", result_q, pin_res);
                chk("pin_zero_q", {31'b0, zero_q}, {31'b0, pin_zero});
            end
        end

        if (reset) begin
            lost   = 0;
            owner  = 0;
            m_res  = '0;
            m_zero = 1'b0;
        end else begin
            owner = mc ? 1 : (md ? 2 : 0);
            if (mc || md) begin
                m_res  = mc ? alu_fn(a_cpu, b_cpu, funct_cpu) : alu_fn(a_dma, b_dma, funct_dma);
                m_zero = (m_res == '0);
            end
            lost = (mc && req_dma) ? lost + 1 : 0;
        end
    end

    task automatic drive(input logic rc, input logic [WIDTH-1:0] ac, input logic [WIDTH-1:0] bc,
                         input logic [2:0] fc, input logic rd, input logic [WIDTH-1:0] ad,
                         input logic [WIDTH-1:0] bd, input logic [2:0] fd);
        req_cpu = rc; a_cpu = ac; b_cpu = bc; funct_cpu = fc;
        req_dma = rd; a_dma = ad; b_dma = bd; funct_dma = fd;
    endtask

    task automatic pin(input logic gc, input logic gd, input logic den, input logic dc, input logic dd,
                       input logic ren, input logic [WIDTH-1:0] res, input logic z);
        pin_vld = 1'b1;
        pin_gc = gc; pin_gd = gd;
        pin_done_en = den; pin_dc = dc; pin_dd = dd;
        pin_res_en = ren; pin_res = res; pin_zero = z;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        pin_vld = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 3'b000, 1'b0, '0, '0, 3'b000);
    endtask

    initial begin
        logic prev_gc;
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;

        // Reset with both requesting: nothing granted, registers cleared
        drive(1'b1, 32'd9, 32'd9, 3'b000, 1'b1, 32'd8, 32'd8, 3'b000);
        repeat (3) begin
            pin(0, 0, 1, 0, 0, 1, 32'd0, 0);
            step();
        end
        reset = 1'b0;

        // CPU only: 5 - 3
        drive(1'b1, 32'd5, 32'd3, 3'b001, 1'b0, '0, '0, 3'b000);
        pin(1, 0, 1, 0, 0, 1, 32'd0, 0);
        step();
        idle();
        pin(0, 0, 1, 1, 0, 1, 32'd2, 0);
        step();
        pin(0, 0, 1, 0, 0, 1, 32'd2, 0);
        step();

        // Continuous contention: C C C C D C C C C D
        prev_gc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, i, 32'd1, 3'b000, 1'b1, 32'h100 + i, 32'h10, 3'b001);
            pin((i % 5) != 4, (i % 5) == 4, i > 0, (i > 0) && prev_gc, (i > 0) && !prev_gc, 0, '0, 0);
            prev_gc = ((i % 5) != 4);
            step();
        end
        idle();
        pin(0, 0, 1, 0, 1, 1, 32'hF9, 0);
        step();

        // DMA back-to-back address increments
        drive(1'b0, '0, '0, 3'b000, 1'b1, 32'h100, 32'd4, 3'b000);
        pin(0, 1, 1, 0, 0, 0, '0, 0);
        step();
        drive(1'b0, '0, '0, 3'b000, 1'b1, 32'h104, 32'd4, 3'b000);
        pin(0, 1, 1, 0, 1, 1, 32'h104, 0);
        step();
        drive(1'b0, '0, '0, 3'b000, 1'b1, 32'h108, 32'd4, 3'b000);
        pin(0, 1, 1, 0, 1, 1, 32'h108, 0);
        step();
        idle();
        pin(0, 0, 1, 0, 1, 1, 32'h10C, 0);
        step();

        // CPU 7 - 7 granted, then reset discards it
        drive(1'b1, 32'd7, 32'd7, 3'b001, 1'b0, '0, '0, 3'b000);
        pin(1, 0, 1, 0, 0, 0, '0, 0);
        step();
        reset = 1'b1;
        drive(1'b1, 32'd1, 32'd1, 3'b000, 1'b1, 32'd2, 32'd2, 3'b000);
        pin(0, 0, 0, 0, 0, 0, '0, 0);
        step();
        reset = 1'b0;
        idle();
        pin(0, 0, 1, 0, 0, 1, 32'd0, 0);
        step();
        drive(1'b1, 32'd7, 32'd7, 3'b001, 1'b0, '0, '0, 3'b000);
        pin(1, 0, 1, 0, 0, 1, 32'd0, 0);
        step();
        idle();
        pin(0, 0, 1, 1, 0, 1, 32'd0, 1);
        step();

        // DMA drops its request exactly when it would have been forced through
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hA0 + i, 32'd2, 3'b011, 1'b1, 32'hB0, 32'd1, 3'b100);
            pin(1, 0, 0, 0, 0, 0, '0, 0);
            step();
        end
        drive(1'b1, 32'hF0, 32'h0F, 3'b100, 1'b0, '0, '0, 3'b000);
        pin(1, 0, 1, 1, 0, 0, '0, 0);
        step();
        drive(1'b1, 32'h0, 32'h0, 3'b110, 1'b1, 32'hB0, 32'd1, 3'b000);
        pin(1, 0, 1, 1, 0, 1, 32'hFF, 0);
        step();
        idle();
        pin(0, 0, 1, 1, 0, 1, 32'hFFFF_FFFF, 0);
        step();
        step();

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
